// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port synchronous RAM with byte enables, selectable
// same-port read-during-write behaviour, optional output register and
// deterministic same-address collision resolution.
// Optional macro DP_RAM_COLL_CNT_EN adds a saturating collision counter
// (coll_clr input, coll_count output).
module dual_port_ram_be #(
  parameter int width    = 32,
  parameter int depth    = 256,
  parameter int rdw_mode = 0,   // 0 read-first, 1 write-first, 2 no-change
  parameter int out_reg  = 0,
  parameter int prio_b   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_a,
  input  logic                     we_a,
  input  logic [width/8-1:0]       be_a,
  input  logic [$clog2(depth)-1:0] addr_a,
  input  logic [width-1:0]         data_in_a,
  output logic [width-1:0]         data_out_a,
  output logic                     valid_a,
  input  logic                     en_b,
  input  logic                     we_b,
  input  logic [width/8-1:0]       be_b,
  input  logic [$clog2(depth)-1:0] addr_b,
  input  logic [width-1:0]         data_in_b,
  output logic [width-1:0]         data_out_b,
  output logic                     valid_b,
  output logic                     collision
`ifdef DP_RAM_COLL_CNT_EN
  ,
  input  logic                     coll_clr,
  output logic [15:0]              coll_count
`endif
);

  localparam int nb = width / 8;
  localparam int aw = $clog2(depth);
  localparam logic pb = (prio_b != 0);

  logic [width-1:0] mem [depth];

  logic             wr_a, wr_b, rng_a, rng_b, same_addr, coll_now;
  logic [nb-1:0]    wmask_a, wmask_b;
  logic [width-1:0] old_a, old_b, nxt_a, nxt_b;
  logic             ld_a, ld_b, vld_a, vld_b;
  logic [width-1:0] s1_data_a, s1_data_b;
  logic             s1_valid_a, s1_valid_b;

  function automatic logic in_rng(input logic [aw-1:0] a);
    return int'(a) < depth;
  endfunction

  function automatic logic [width-1:0] merge(input logic [width-1:0] old,
                                             input logic [width-1:0] din,
                                             input logic [nb-1:0] be);
    logic [width-1:0] r;
    r = old;
    for (int i = 0; i < nb; i++)
      if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  // Access decode, collision detection and per-byte write ownership.
  // An out-of-range address never writes and never collides; on a
  // write-write collision the losing port gives up only the shared bytes.
  always_comb begin
    wr_a      = en_a & we_a;
    wr_b      = en_b & we_b;
    rng_a     = in_rng(addr_a);
    rng_b     = in_rng(addr_b);
    same_addr = en_a & en_b & (addr_a == addr_b);
    coll_now  = same_addr & (wr_a | wr_b) & rng_a;
    for (int i = 0; i < nb; i++) begin
      wmask_a[i] = wr_a & rng_a & be_a[i] & ~(same_addr & wr_b & be_b[i] & pb);
      wmask_b[i] = wr_b & rng_b & be_b[i] & ~(same_addr & wr_a & be_a[i] & ~pb);
    end
  end

  // Port A read result; reads always see the pre-edge array, which gives
  // read-first behaviour against the other port's write.
  always_comb begin
    old_a = rng_a ? mem[addr_a] : '0;
    nxt_a = old_a;
    ld_a  = 1'b0;
    vld_a = 1'b0;
    if (en_a) begin
      if (!wr_a || rdw_mode == 0) begin
        ld_a  = 1'b1;
        vld_a = 1'b1;
      end else if (rdw_mode == 1) begin
        ld_a  = 1'b1;
        vld_a = 1'b1;
        nxt_a = rng_a ? merge(old_a, data_in_a, be_a) : '0;
      end
    end
  end

  // Port B read result, mirror of port A.
  always_comb begin
    old_b = rng_b ? mem[addr_b] : '0;
    nxt_b = old_b;
    ld_b  = 1'b0;
    vld_b = 1'b0;
    if (en_b) begin
      if (!wr_b || rdw_mode == 0) begin
        ld_b  = 1'b1;
        vld_b = 1'b1;
      end else if (rdw_mode == 1) begin
        ld_b  = 1'b1;
        vld_b = 1'b1;
        nxt_b = rng_b ? merge(old_b, data_in_b, be_b) : '0;
      end
    end
  end

  // Byte-granular array update; masks are disjoint on shared bytes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < nb; i++) begin
        if (wmask_a[i]) mem[addr_a][8*i +: 8] <= data_in_a[8*i +: 8];
        if (wmask_b[i]) mem[addr_b][8*i +: 8] <= data_in_b[8*i +: 8];
      end
    end
  end

  // First read stage and collision flag; data holds when nothing loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_a  <= '0;
      s1_data_b  <= '0;
      s1_valid_a <= 1'b0;
      s1_valid_b <= 1'b0;
      collision  <= 1'b0;
    end else begin
      s1_valid_a <= vld_a;
      s1_valid_b <= vld_b;
      collision  <= coll_now;
      if (ld_a) s1_data_a <= nxt_a;
      if (ld_b) s1_data_b <= nxt_b;
    end
  end

  if (out_reg != 0) begin : g_oreg
    // Second stage: data and valid move together.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_a <= '0;
        data_out_b <= '0;
        valid_a    <= 1'b0;
        valid_b    <= 1'b0;
      end else begin
        data_out_a <= s1_data_a;
        data_out_b <= s1_data_b;
        valid_a    <= s1_valid_a;
        valid_b    <= s1_valid_b;
      end
    end
  end else begin : g_noreg
    assign data_out_a = s1_data_a;
    assign data_out_b = s1_data_b;
    assign valid_a    = s1_valid_a;
    assign valid_b    = s1_valid_b;
  end

`ifdef DP_RAM_COLL_CNT_EN
  // Saturating count of cycles with collision high; clear wins.
  always_ff @(posedge clk) begin
    if (rst || coll_clr)
      coll_count <= '0;
    else if (collision && coll_count != 16'hFFFF)
      coll_count <= coll_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb_dual_port_ram_be: directed checks for dual_port_ram_be across several
// parameter sets driven by one shared stimulus stream.
// u0 default, u1 write-first + B priority, u2 no-change, u3 output register,
// u4 depth 6 (non power of two, 3-bit address).
`ifdef DP_RAM_COLL_CNT_EN
`define CNT_CONN(i) , .coll_clr(clr[i]), .coll_count(cnt[i])
`else
`define CNT_CONN(i)
`endif

module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] douta [5];
  logic [31:0] doutb [5];
  logic        va [5];
  logic        vb [5];
  logic        col [5];
  logic        clr [5];
  logic [15:0] cnt [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_port_ram_be #(.width(32), .depth(256)) u0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(douta[0]), .valid_a(va[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(doutb[0]), .valid_b(vb[0]), .collision(col[0]) `CNT_CONN(0));

  dual_port_ram_be #(.width(32), .depth(256), .rdw_mode(1), .prio_b(1)) u1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(douta[1]), .valid_a(va[1]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(doutb[1]), .valid_b(vb[1]), .collision(col[1]) `CNT_CONN(1));

  dual_port_ram_be #(.width(32), .depth(256), .rdw_mode(2)) u2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(douta[2]), .valid_a(va[2]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(doutb[2]), .valid_b(vb[2]), .collision(col[2]) `CNT_CONN(2));

  dual_port_ram_be #(.width(32), .depth(256), .out_reg(1)) u3 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(douta[3]), .valid_a(va[3]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(doutb[3]), .valid_b(vb[3]), .collision(col[3]) `CNT_CONN(3));

  dual_port_ram_be #(.width(32), .depth(6)) u4 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a[2:0]), .data_in_a(din_a),
    .data_out_a(douta[4]), .valid_a(va[4]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b[2:0]), .data_in_b(din_b),
    .data_out_b(doutb[4]), .valid_b(vb[4]), .collision(col[4]) `CNT_CONN(4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; en_b = 0; we_b = 0;
  endtask

  task automatic a_wr(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] be);
    en_a = 1; we_a = 1; addr_a = ad; din_a = d; be_a = be;
  endtask

  task automatic b_wr(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] be);
    en_b = 1; we_b = 1; addr_b = ad; din_b = d; be_b = be;
  endtask

  task automatic a_rd(input logic [7:0] ad);
    en_a = 1; we_a = 0; addr_a = ad; be_a = 4'h0;
  endtask

  task automatic b_rd(input logic [7:0] ad);
    en_b = 1; we_b = 0; addr_b = ad; be_b = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) clr[i] = 1'b0;
    rst = 1; idle();
    be_a = 0; be_b = 0; addr_a = 0; addr_b = 0; din_a = 0; din_b = 0;
    tick(); tick();
    rst = 0;
    chk("rst_dout_a", douta[0], 32'h0);
    chk("rst_valid_a", {31'b0, va[0]}, 32'h0);
    chk("rst_coll", {31'b0, col[0]}, 32'h0);
    chk("rst_valid_b_oreg", {31'b0, vb[3]}, 32'h0);

    // basic write then cross-port read
    a_wr(8'h10, 32'hDEADBEEF, 4'hF); tick();
    idle(); b_rd(8'h10); tick();
    chk("rd_b_data", doutb[0], 32'hDEADBEEF);
    chk("rd_b_valid", {31'b0, vb[0]}, 32'h1);
    chk("rd_b_coll", {31'b0, col[0]}, 32'h0);
    chk("idle_a_valid", {31'b0, va[0]}, 32'h0);

    // byte enables and same-port read-during-write
    idle(); a_wr(8'h20, 32'h11223344, 4'hF); tick();
    a_wr(8'h20, 32'hAABBCCDD, 4'b0101); tick();
    chk("rdw0_pre_word", douta[0], 32'h11223344);
    chk("rdw1_post_word", douta[1], 32'h11BB33DD);
    chk("rdw2_valid", {31'b0, va[2]}, 32'h0);
    idle(); b_rd(8'h20); tick();
    chk("be_readback", doutb[0], 32'h11BB33DD);

    // write-write collision, then back-to-back collision
    idle(); a_wr(8'h30, 32'h0, 4'hF); tick();
    a_wr(8'h30, 32'hAAAAAAAA, 4'b0011); b_wr(8'h30, 32'hBBBBBBBB, 4'b0110); tick();
    chk("ww_coll", {31'b0, col[0]}, 32'h1);
    chk("ww_coll_oreg", {31'b0, col[3]}, 32'h1);
    chk("ww_a_pre", douta[0], 32'h0);
    a_wr(8'h31, 32'h1, 4'hF); b_wr(8'h31, 32'h2, 4'hF); tick();
    chk("b2b_coll", {31'b0, col[0]}, 32'h1);
    idle(); b_rd(8'h30); tick();
    chk("coll_drop", {31'b0, col[0]}, 32'h0);
    chk("ww_prio_a", doutb[0], 32'h00BBAAAA);
    chk("ww_prio_b", doutb[1], 32'h00BBBBAA);

    // read versus cross-port write
    idle(); a_wr(8'h40, 32'h12345678, 4'hF); tick();
    a_rd(8'h40); b_wr(8'h40, 32'h87654321, 4'hF); tick();
    chk("rw_read_first", douta[0], 32'h12345678);
    chk("rw_read_first_m1", douta[1], 32'h12345678);
    chk("rw_coll", {31'b0, col[0]}, 32'h1);
    idle(); a_rd(8'h40); tick();
    chk("rw_after", douta[0], 32'h87654321);

    // read-during-write mode sweep at address 5
    idle(); a_wr(8'h05, 32'h1, 4'hF); tick();
    a_wr(8'h05, 32'h2, 4'hF); tick();
    chk("sweep_m0", douta[0], 32'h1);
    chk("sweep_m1", douta[1], 32'h2);
    chk("sweep_m2_hold", douta[2], 32'h87654321);
    chk("sweep_m2_valid", {31'b0, va[2]}, 32'h0);
    a_rd(8'h05); b_rd(8'h05); tick();
    chk("rr_a", douta[0], 32'h2);
    chk("rr_b", doutb[0], 32'h2);
    chk("rr_no_coll", {31'b0, col[0]}, 32'h0);
    idle(); tick();
    chk("idle_hold", douta[0], 32'h2);
    chk("idle_valid", {31'b0, va[0]}, 32'h0);

    // out-of-range on depth 6 (address 7)
    a_wr(8'h07, 32'hCAFEF00D, 4'hF); b_wr(8'h07, 32'h55555555, 4'hF); tick();
    chk("oor_no_coll", {31'b0, col[4]}, 32'h0);
    chk("oor_coll_inrange", {31'b0, col[0]}, 32'h1);
    chk("oor_wr_data", douta[4], 32'h0);
    chk("oor_wr_valid", {31'b0, va[4]}, 32'h1);
    idle(); a_rd(8'h07); tick();
    chk("oor_rd_data", douta[4], 32'h0);
    chk("oor_rd_valid", {31'b0, va[4]}, 32'h1);
    chk("inrange_prio_a", douta[0], 32'hCAFEF00D);

    // output register pipeline
    idle(); a_wr(8'h00, 32'h100, 4'hF); tick();
    a_wr(8'h01, 32'h101, 4'hF); tick();
    a_wr(8'h02, 32'h102, 4'hF); tick();
    idle(); b_rd(8'h00); tick();
    chk("oreg_lat_valid", {31'b0, vb[3]}, 32'h0);
    b_rd(8'h01); tick();
    chk("oreg_d0", doutb[3], 32'h100);
    chk("oreg_v0", {31'b0, vb[3]}, 32'h1);
    b_rd(8'h02); tick();
    chk("oreg_d1", doutb[3], 32'h101);
    chk("oreg_v1", {31'b0, vb[3]}, 32'h1);
    idle(); tick();
    chk("oreg_d2", doutb[3], 32'h102);
    chk("oreg_v2", {31'b0, vb[3]}, 32'h1);

    // reset mid-stream with a write attempt
    b_rd(8'h00); tick();
    rst = 1; b_rd(8'h01); a_wr(8'h02, 32'hFFFFFFFF, 4'hF); tick();
    chk("rst_oreg_data", doutb[3], 32'h0);
    chk("rst_oreg_valid", {31'b0, vb[3]}, 32'h0);
    rst = 0; idle(); b_rd(8'h02); tick();
    chk("rst_drop_valid", {31'b0, vb[3]}, 32'h0);
    chk("rst_wr_ignored", doutb[0], 32'h102);
    idle(); tick();
    chk("rst_wr_ignored_oreg", doutb[3], 32'h102);
    chk("rst_oreg_valid_back", {31'b0, vb[3]}, 32'h1);

`ifdef DP_RAM_COLL_CNT_EN
    chk("cnt_rst", {16'b0, cnt[0]}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      a_wr(8'h50, 32'h0, 4'hF); b_rd(8'h50); tick();
    end
    idle(); tick();
    chk("cnt_three", {16'b0, cnt[0]}, 32'h3);
    a_wr(8'h50, 32'h0, 4'hF); b_rd(8'h50); tick();
    idle(); clr[0] = 1; tick();
    chk("cnt_clr_wins", {16'b0, cnt[0]}, 32'h0);
    clr[0] = 0; a_wr(8'h50, 32'h0, 4'hF); b_rd(8'h50); tick();
    idle();
    force u0.coll_count = 16'hFFFF;
    #1;
    release u0.coll_count;
    tick();
    chk("cnt_saturate", {16'b0, cnt[0]}, 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Parametrised true dual-port synchronous RAM, successor to the basic dual-port RAM. Adds per-port enables, byte-write enables, selectable read-during-write mode, an optional output pipeline register with a matching valid flag, and deterministic cross-port collision resolution with a collision flag. Used as shared buffer or register-file storage between two independent masters in one clock domain.

Parameters:
width, 32, data width in bits; must be a multiple of 8
depth, 256, number of words; any value >= 2
rdw_mode, 0, same-port read-during-write: 0 read-first, 1 write-first, 2 no-change
out_reg, 0, 1 adds an output pipeline register (read latency 2 instead of 1)
prio_b, 0, 0 gives port A priority on write-write collisions, 1 gives port B priority

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en_a  in  1  port A access enable
we_a  in  1  port A write enable; qualified by en_a
be_a  in  width/8  port A byte enables; bit i covers data bits 8i+7..8i
addr_a  in  $clog2(depth)  port A word address
data_in_a  in  width  port A write data
data_out_a  out  width  port A read data
valid_a  out  1  data_out_a holds the result of an access
en_b, we_b, be_b, addr_b, data_in_b, data_out_b, valid_b: port B, same widths and meanings as port A
collision  out  1  one-cycle pulse: the previous cycle had a same-address collision

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset: data_out_a/b = 0, valid_a/b = 0, collision = 0, pipeline stages cleared. Memory contents are not cleared. Accesses presented in a cycle with rst=1 are ignored, including writes. In-flight reads are dropped, and valid stays 0 until a new access completes.
- Access: a port is active when en=1. A write is en&we. Only bytes with be=1 are updated. A write with be=0 is legal and changes no memory, but still counts as a write for rdw_mode and collision purposes.
- Read latency: out_reg=0 -> data/valid appear on the edge after the access (1 cycle). out_reg=1 -> 2 cycles. valid is pipelined with the data. The port is fully pipelined and accepts one access per cycle.
- Same-port write data returned:
  - rdw_mode 0: pre-write word.
  - rdw_mode 1: post-write word, with bytes where be=0 keeping old data.
  - rdw_mode 2: data_out holds its previous value and valid is 0 for that access.
- Idle port (en=0): data_out holds its value; valid is 0 in the corresponding cycle.
- Out-of-range address (addr >= depth, non-power-of-2 depth): the write is ignored, a read returns 0 with valid=1, and no collision is flagged.
- Collision: both ports enabled, addr_a==addr_b, and at least one port writing.
  - Write-write: per byte. A byte enabled on both ports takes the priority port's data. A byte enabled on one port only takes that port's data.
  - Read vs cross-port write: the reader returns the pre-write word (read-first across ports), regardless of rdw_mode.
  - collision=1 for exactly one cycle, on the edge after the colliding access, independent of out_reg. Back-to-back collisions keep it high.
- Read-read on the same address is not a collision: both ports return the same word.

Optional Feature:
DP_RAM_COLL_CNT_EN:
- Defined: adds input coll_clr (1 bit) and output coll_count (16 bits). coll_count increments on every cycle where collision is set and saturates at 16'hFFFF.
- coll_clr=1 zeroes coll_count on the next edge and takes precedence over an increment in the same cycle. rst also zeroes coll_count.
- Not defined: the ports and counter logic do not exist. Core behaviour is identical either way.

Test Plan:
- Default params. A writes 0xDEADBEEF @0x10, be=4'hF. Next cycle B reads 0x10 -> data_out_b=0xDEADBEEF, valid_b=1 one cycle later, collision=0.
- Byte enables: mem[0x20]=0x11223344, then A writes 0xAABBCCDD with be=4'b0101 -> readback 0x11BB33DD.
- Write-write collision: A writes 0xAAAAAAAA be=4'b0011 and B writes 0xBBBBBBBB be=4'b0110, both @0x30, same cycle, prio_b=0 -> mem = 0x00BBAAAA if previously 0. collision pulses 1 cycle.
- rdw_mode sweep with mem[5]=0x1, A writes 0x2 @5:
  - rdw_mode=0 -> data_out_a=0x1.
  - rdw_mode=1 -> data_out_a=0x2.
  - rdw_mode=2 -> data_out_a unchanged and valid_a=0.
- out_reg=1: back-to-back reads of 0,1,2 on B -> data at cycles +2,+3,+4 with valid_b continuous. rst asserted mid-stream -> valid_b=0 and data_out_b=0 next edge; a write attempted during rst leaves memory unchanged.
- DP_RAM_COLL_CNT_EN: 3 collisions -> coll_count=3. coll_clr together with a 4th collision -> 0. Counter forced to 0xFFFF stays 0xFFFF on a further collision.
